twos_to_signmag_serial: RTL and testbench
=========================================

Name: twos_to_signmag_serial

Overview:
- Decoder counterpart to the team's 4-bit two's complement generator: converts a two's complement word back into sign + magnitude form.
- Bit-serial (LSB-first) engine using the "copy up to and including first 1, invert the rest" rule.
- Sits between arithmetic datapaths and display/BCD logic that needs unsigned magnitudes.
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 4, word width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  two's complement operand.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_sign  output  1  1 = operand was negative.
- out_mag  output  WIDTH  unsigned magnitude |in_data|.
- out_minneg  output  1  operand was the most negative value, -2^(WIDTH-1).

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-conversion):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, out_sign=0, out_mag=0, out_minneg=0.
  - Internal shift register, bit counter and seen_one flag are cleared.
  - Any in-flight word is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge, the word is accepted:
    - latch in_data into the shift register;
    - sign <= in_data[WIDTH-1];
    - counter <= 0, seen_one <= 0, result register <= 0;
    - go to SHIFT.
- SHIFT:
  - in_ready=0; in_valid is ignored and the word is not consumed.
  - Each cycle processes one bit b = shreg[0], then shifts shreg right:
    - sign=0: result bit = b.
    - sign=1, seen_one=0: result bit = b, then seen_one <= b.
    - sign=1, seen_one=1: result bit = ~b.
  - Result bits fill a WIDTH-bit register from the MSB side (shift-in right), so bit k of the operand lands at bit k of out_mag.
  - counter increments every cycle. After exactly WIDTH SHIFT cycles (counter == WIDTH-1 processed), go to DONE.
- DONE:
  - out_valid=1; out_sign, out_mag and out_minneg are stable.
  - out_minneg = sign & (out_mag == 2^(WIDTH-1)).
  - Outputs hold while out_ready=0 for any number of cycles.
  - On out_ready=1 at an edge: out_valid drops, go to IDLE.
  - The next word can be accepted no earlier than the following edge; there is no same-cycle turnaround.
- Timing:
  - Latency: word accepted at edge N -> out_valid=1 in the cycle after edge N+WIDTH.
  - Minimum initiation interval: WIDTH+2 cycles.
- Outputs are registered. out_mag/out_sign keep their last value after leaving DONE until the next conversion completes (the value is only meaningful while out_valid=1).
- Zero operand: sign=0, mag=0, minneg=0.
- Most negative operand: mag = 2^(WIDTH-1) (fits unsigned in WIDTH bits), sign=1, minneg=1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Positive value, WIDTH=4: in_data=0101 accepted at edge 0 -> out_valid=1 after edge 4, out_sign=0, out_mag=0101, out_minneg=0; out_ready=1 -> IDLE, in_ready=1.
- Negative values: 1011 (-5) -> sign=1, mag=0101. 1110 (-2) -> sign=1, mag=0010. 1111 (-1) -> sign=1, mag=0001.
- Boundary values: 1000 -> sign=1, mag=1000, minneg=1. 0000 -> sign=0, mag=0000, minneg=0. 0111 -> sign=0, mag=0111.
- Backpressure and busy behaviour:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and outputs are unchanged; release -> one transfer only.
  - in_valid=1 with in_data=0011 during SHIFT -> in_ready=0 and the word is not consumed.
- Reset mid-operation: assert rst_n=0 asynchronously (between edges) during the 2nd SHIFT cycle of operand 1010 -> all outputs 0 and in_ready=1 immediately. After release, 0110 converts cleanly to sign=0, mag=0110.
- Exhaustive sweep: for all 16 values, the scoreboard checks (sign ? -mag : mag) == $signed(in_data). Repeat with WIDTH=8 using 256 values and back-to-back in_valid.

Source files
------------

// File: rtl/twos_to_signmag_serial_if.sv
// Handshake bundle for the serial two's complement -> sign/magnitude decoder.
// The master drives operands and accepts results; the slave is the decoder.
interface twos_to_signmag_serial_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_sign;
   logic [WIDTH-1:0] out_mag;
   logic             out_minneg;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sign, out_mag, out_minneg
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sign, out_mag, out_minneg
   );
endinterface

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial LSB-first two's complement to sign/magnitude decoder.
// Negative words use copy-through-first-one-then-invert; one bit per cycle.
module twos_to_signmag_serial #(
   parameter int WIDTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   twos_to_signmag_serial_if.slave       io
);
   localparam int               CW         = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST       = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MINNEG_MAG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             seen_q, seen_d;
   logic             sign_q, sign_d;
   logic             osign_q, osign_d;
   logic [WIDTH-1:0] omag_q, omag_d;
   logic             ominneg_q, ominneg_d;
   logic             rbit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         res_q     <= '0;
         cnt_q     <= '0;
         seen_q    <= 1'b0;
         sign_q    <= 1'b0;
         osign_q   <= 1'b0;
         omag_q    <= '0;
         ominneg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         res_q     <= res_d;
         cnt_q     <= cnt_d;
         seen_q    <= seen_d;
         sign_q    <= sign_d;
         osign_q   <= osign_d;
         omag_q    <= omag_d;
         ominneg_q <= ominneg_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      res_d     = res_q;
      cnt_d     = cnt_q;
      seen_d    = seen_q;
      sign_d    = sign_q;
      osign_d   = osign_q;
      omag_d    = omag_q;
      ominneg_d = ominneg_q;
      rbit      = shreg_q[0];
      case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               shreg_d = io.in_data;
               sign_d  = io.in_data[WIDTH-1];
               cnt_d   = '0;
               seen_d  = 1'b0;
               res_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // After the first 1 of a negative word every later bit flips.
            rbit = (sign_q & seen_q) ? ~shreg_q[0] : shreg_q[0];
            if (sign_q && !seen_q) seen_d = shreg_q[0];
            res_d   = {rbit, res_q[WIDTH-1:1]};
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d   = DONE;
               osign_d   = sign_q;
               omag_d    = res_d;
               ominneg_d = sign_q & (res_d == MINNEG_MAG);
            end
         end
         DONE: begin
            if (io.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake flags come straight from the state register, never from inputs.
   assign io.in_ready   = (state_q == IDLE);
   assign io.out_valid  = (state_q == DONE);
   assign io.out_sign   = osign_q;
   assign io.out_mag    = omag_q;
   assign io.out_minneg = ominneg_q;
endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Scoreboard bench for twos_to_signmag_serial at WIDTH=4 and WIDTH=8.
module tb_twos_to_signmag_serial;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   twos_to_signmag_serial_if #(.WIDTH(4)) if4 ();
   twos_to_signmag_serial_if #(.WIDTH(8)) if8 ();

   twos_to_signmag_serial #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .io(if4));
   twos_to_signmag_serial #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .io(if8));

   typedef struct {
      logic [7:0] d;
      logic       s;
      logic [7:0] m;
      logic       mn;
      int         sv;
   } exp_t;

   exp_t q4[$];
   exp_t q8[$];
   int   checks   = 0;
   int   failures = 0;
   int   xfer4    = 0;
   int   xfer8    = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int w, input logic [7:0] d);
      exp_t e;
      e.d  = d;
      e.sv = d[w-1] ? int'(d) - (1 << w) : int'(d);
      e.s  = (e.sv < 0);
      e.m  = 8'((e.sv < 0) ? -e.sv : e.sv);
      e.mn = (e.sv == -(1 << (w-1)));
      return e;
   endfunction

   // Returns #1 after the accepting edge.
   task automatic send4(input logic [3:0] d, input bit keep);
      bit ok = 1'b0;
      if4.in_valid = 1'b1;
      if4.in_data  = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (if4.in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("acc4_timeout", 0, 1);
      else begin
         @(posedge clk);
         q4.push_back(model(4, {4'b0, d}));
      end
      #1;
      if (!keep) if4.in_valid = 1'b0;
   endtask

   task automatic send8(input logic [7:0] d, input bit keep);
      bit ok = 1'b0;
      if8.in_valid = 1'b1;
      if8.in_data  = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (if8.in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("acc8_timeout", 0, 1);
      else begin
         @(posedge clk);
         q8.push_back(model(8, d));
      end
      #1;
      if (!keep) if8.in_valid = 1'b0;
   endtask

   task automatic drain4();
      bit ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (q4.size() == 0 && !if4.out_valid) begin ok = 1'b1; break; end
      end
      chk("drain4", 32'(ok), 1);
   endtask

   task automatic drain8();
      bit ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (q8.size() == 0 && !if8.out_valid) begin ok = 1'b1; break; end
      end
      chk("drain8", 32'(ok), 1);
   endtask

   always @(negedge clk) begin
      if (rst_n && if4.out_valid && if4.out_ready) begin
         xfer4++;
         if (q4.size() == 0) chk("sb4_unexpected", 1, 0);
         else begin
            exp_t e;
            int   r;
            e = q4.pop_front();
            r = if4.out_sign ? -int'(if4.out_mag) : int'(if4.out_mag);
            chk("sb4_sign", 32'(if4.out_sign), 32'(e.s));
            chk("sb4_mag", 32'(if4.out_mag), 32'(e.m));
            chk("sb4_minneg", 32'(if4.out_minneg), 32'(e.mn));
            chk("sb4_value", r, e.sv);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && if8.out_valid && if8.out_ready) begin
         xfer8++;
         if (q8.size() == 0) chk("sb8_unexpected", 1, 0);
         else begin
            exp_t e;
            int   r;
            e = q8.pop_front();
            r = if8.out_sign ? -int'(if8.out_mag) : int'(if8.out_mag);
            chk("sb8_sign", 32'(if8.out_sign), 32'(e.s));
            chk("sb8_mag", 32'(if8.out_mag), 32'(e.m));
            chk("sb8_minneg", 32'(if8.out_minneg), 32'(e.mn));
            chk("sb8_value", r, e.sv);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int x0;
      bit ok;
      rst_n = 1'b0;
      if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b1;
      if8.in_valid = 1'b0; if8.in_data = '0; if8.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(if4.in_ready), 1);
      chk("rst_out_valid", 32'(if4.out_valid), 0);
      chk("rst_out_sign", 32'(if4.out_sign), 0);
      chk("rst_out_mag", 32'(if4.out_mag), 0);
      chk("rst_out_minneg", 32'(if4.out_minneg), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: out_valid appears only after the WIDTH-th edge past acceptance.
      send4(4'b0101, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         chk("lat_out_valid", 32'(if4.out_valid), 32'(k == 4));
      end
      chk("lat_mag", 32'(if4.out_mag), 32'h5);
      @(posedge clk); #1;
      chk("post_in_ready", 32'(if4.in_ready), 1);
      chk("post_out_valid", 32'(if4.out_valid), 0);

      foreach (q4[i]) chk("q4_leftover", 1, 0);
      send4(4'b1011, 1'b0); drain4();
      send4(4'b1110, 1'b0); drain4();
      send4(4'b1111, 1'b0); drain4();
      send4(4'b1000, 1'b0); drain4();
      chk("minneg_held", 32'(if4.out_minneg), 1);
      send4(4'b0000, 1'b0); drain4();
      send4(4'b0111, 1'b0); drain4();

      // Backpressure: hold DONE for five cycles, then release for one transfer.
      if4.out_ready = 1'b0;
      send4(4'b1101, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (if4.out_valid) begin ok = 1'b1; break; end
      end
      chk("bp_reach_done", 32'(ok), 1);
      x0 = xfer4;
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", 32'(if4.out_valid), 1);
         chk("bp_hold_mag", 32'(if4.out_mag), 32'h3);
         chk("bp_hold_sign", 32'(if4.out_sign), 1);
      end
      if4.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", 32'(if4.out_valid), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_one_xfer", xfer4 - x0, 1);

      // Busy: a word offered during SHIFT must not be consumed.
      x0 = xfer4;
      send4(4'b0101, 1'b0);
      if4.in_valid = 1'b1;
      if4.in_data  = 4'b0011;
      repeat (2) begin
         @(negedge clk);
         chk("busy_in_ready", 32'(if4.in_ready), 0);
         @(posedge clk);
      end
      #1;
      if4.in_valid = 1'b0;
      drain4();
      repeat (4) @(posedge clk);
      #1;
      chk("busy_one_xfer", xfer4 - x0, 1);

      // Asynchronous reset during the second SHIFT cycle.
      send4(4'b1010, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", 32'(if4.in_ready), 1);
      chk("arst_out_valid", 32'(if4.out_valid), 0);
      chk("arst_out_mag", 32'(if4.out_mag), 0);
      chk("arst_out_sign", 32'(if4.out_sign), 0);
      chk("arst_out_minneg", 32'(if4.out_minneg), 0);
      q4.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      send4(4'b0110, 1'b0);
      drain4();
      chk("arst_after_mag", 32'(if4.out_mag), 32'h6);

      // Exhaustive sweeps with back-to-back in_valid.
      for (int v = 0; v < 16; v++) send4(4'(v), 1'b1);
      if4.in_valid = 1'b0;
      drain4();
      for (int v = 0; v < 256; v++) send8(8'(v), 1'b1);
      if8.in_valid = 1'b0;
      drain8();
      chk("xfer8_count", xfer8, 256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
